// File: rtl/bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bcd_pkg                                                 |
// | Brief    : Shared types, constants and sizing helper for the       |
// |            shift-and-add-3 binary-to-BCD converters.               |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
   localparam logic [3:0] ADJ_OFFSET    = 4'd3;

   // Decimal digits needed to represent the largest WIDTH-bit unsigned value.
   function automatic int min_digits(input int width);
      longint unsigned v;
      int              n;
      v = (64'd1 << width) - 64'd1;
      n = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
         end
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bcd_digit_adj                                           |
// | Brief    : Single-digit add-3 correction cell for double dabble.   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= ADJ_THRESHOLD) ? (i_digit + ADJ_OFFSET) : i_digit;

endmodule
`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : binary_to_bcd_seq                                       |
// | Brief    : Iterative binary-to-BCD converter, one bit per clock,   |
// |            optional two's-complement input with sign output.       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module binary_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3,
   parameter int SIGNED = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [WIDTH-1:0]      i_a,
   output logic                  o_ready,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_neg
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   if ((WIDTH < 2) || (WIDTH > 32)) begin : g_width_check
      $error("binary_to_bcd_seq: WIDTH must be in 2..32");
   end

   if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
      $error("binary_to_bcd_seq: DIGITS too small for WIDTH");
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic [BW-1:0]    r_acc;
   logic [WIDTH-1:0] r_mag;
   logic [CW-1:0]    r_cnt;
   logic             r_sign;
   logic [BW-1:0]    r_bcd;
   logic             r_neg;

   logic [BW-1:0]    w_adj;
   logic [BW-1:0]    w_shift_acc;
   logic [WIDTH-1:0] w_shift_mag;
   logic [WIDTH-1:0] w_mag_in;
   logic             w_neg_in;
   logic             w_accept;
   logic             w_last;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .i_digit (r_acc[4*g +: 4]),
         .o_digit (w_adj[4*g +: 4])
      );
   end

   // The top digit never exceeds 4 before a shift, so its MSB is dropped.
   assign w_shift_acc = {w_adj[BW-2:0], r_mag[WIDTH-1]};
   assign w_shift_mag = {r_mag[WIDTH-2:0], 1'b0};

   assign w_neg_in = (SIGNED != 0) && i_a[WIDTH-1];
   assign w_mag_in = w_neg_in ? ((~i_a) + WIDTH'(1)) : i_a;
   assign w_accept = i_start && (r_state != SHIFT);
   assign w_last   = (r_cnt == CW'(1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_start) w_state_nxt = SHIFT;
         SHIFT:   if (w_last)  w_state_nxt = FIN;
         FIN:     w_state_nxt = i_start ? SHIFT : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc  <= '0;
         r_mag  <= '0;
         r_cnt  <= '0;
         r_sign <= 1'b0;
         r_bcd  <= '0;
         r_neg  <= 1'b0;
      end else if (w_accept) begin
         r_acc  <= '0;
         r_mag  <= w_mag_in;
         r_cnt  <= CW'(WIDTH);
         r_sign <= w_neg_in;
      end else if (r_state == SHIFT) begin
         r_acc <= w_shift_acc;
         r_mag <= w_shift_mag;
         r_cnt <= r_cnt - CW'(1);
         if (w_last) begin
            r_bcd <= w_shift_acc;
            r_neg <= r_sign;
         end
      end
   end

   a_no_top_carry: assert property (@(posedge i_clk) disable iff (i_rst)
      (r_state == SHIFT) |-> !w_adj[BW-1]);

   assign o_ready = (r_state != SHIFT);
   assign o_done  = (r_state == FIN);
   assign o_bcd   = r_bcd;
   assign o_neg   = r_neg;

endmodule
`default_nettype wire

// File: doc/binary_to_bcd_seq.md
Name: binary_to_bcd_seq

Overview:
- Iterative, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble).
- Processes one input bit per clock, so area is one add-3 column per digit instead of a full combinational array.
- Supports any input WIDTH, optional two's-complement input with sign output, and a start/ready/done handshake.
- Sits between arithmetic/counter blocks and display or serial-output drivers that consume packed BCD digits.

Parameters:
- WIDTH, 8, input binary width in bits (2..32).
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1; an elaboration-time check fails otherwise.
- SIGNED, 0, 1 = A is two's complement; conversion uses |A| and NEG reports the sign.

Ports:
- CLK  input  1  single clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request a conversion; sampled only while READY=1.
- A  input  WIDTH  binary operand; sampled on the edge where START&READY.
- READY  output  1  block can accept START this cycle.
- DONE  output  1  one-cycle pulse; BCD/NEG hold a new valid result.
- BCD  output  4*DIGITS  packed result; digit 0 (ones) in bits [3:0], digit k in bits [4k+3:4k].
- NEG  output  1  sign of the last converted operand; always 0 when SIGNED=0.

Behaviour:
- Reset (async assert, any state): state=IDLE, READY=1, DONE=0, BCD=0, NEG=0, shift register and counter cleared. Any conversion in progress is abandoned with no DONE.
- Reset release: the first active edge after RST deasserts may already accept START.
- States: IDLE, SHIFT, FIN.
- IDLE, or FIN, with START=1, on the edge:
  - load magnitude M = (SIGNED && A[WIDTH-1]) ? (~A+1) truncated to WIDTH bits, unsigned : A.
  - capture the sign internally.
  - clear the BCD accumulator; bit counter = WIDTH.
  - go to SHIFT.
- Magnitude edge case: for SIGNED, A = -2^(WIDTH-1) gives M = 2^(WIDTH-1), which is correct as an unsigned WIDTH-bit value.
- SHIFT, each edge:
  - every accumulator digit >= 5 gets +3 (digit value 5..9 maps to 8..12; values above 9 cannot occur).
  - then shift {accumulator, M} left by 1; counter decrements.
  - on the edge where the counter goes 1 -> 0: write the final shifted accumulator to BCD, write the sign to NEG, go to FIN.
- FIN, one cycle: DONE=1, READY=1. Goes to SHIFT if START=1, else to IDLE.
- Output timing:
  - READY = (state != SHIFT), combinational from state.
  - DONE = (state == FIN), registered state decode.
  - BCD/NEG change only on the edge entering FIN and otherwise hold.
- Latency: START sampled at edge E0 -> DONE high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles from E0 to the DONE cycle.
- Throughput: a back-to-back START in FIN is accepted, giving one result every WIDTH+1 cycles.
- START while READY=0 is ignored, not queued. A changing during SHIFT has no effect.
- Zero input gives BCD=0, NEG=0, with normal latency; there is no early termination.
- Counter width is clog2(WIDTH+1). The accumulator is 4*DIGITS bits; no carry leaves the top digit when the DIGITS constraint holds.

Decomposition:
- Package bcd_pkg:
  - state encoding constants IDLE/SHIFT/FIN.
  - function min_digits(width), used for the DIGITS check.
  - constant ADJ_THRESHOLD=5 and ADJ_OFFSET=3.
- Sub-module bcd_digit_adj: combinational 4-bit cell, out = (in >= 5) ? in+3 : in, instantiated DIGITS times in a generate loop. It is the same add-3 cell already used by the combinational converter and can be shared.

Test Plan:
- WIDTH=8, A=8'd255, START one cycle -> READY low 8 cycles, DONE pulse in cycle 9 after START, BCD=12'h255, NEG=0.
- WIDTH=8, A=0 then A=8'd99 issued back-to-back in the FIN cycle -> BCD=12'h000 then 12'h099, DONE pulses 9 cycles apart, no idle cycle between.
- WIDTH=8, SIGNED=1: A=8'h80 -> BCD=12'h128, NEG=1. A=8'hFF -> BCD=12'h001, NEG=1. A=8'h7F -> BCD=12'h127, NEG=0.
- WIDTH=16, DIGITS=5, A=16'hFFFF -> BCD=20'h65535 after 17 cycles. WIDTH=16, DIGITS=4 -> elaboration error.
- Start A=200, then START with A=55 pulsed on cycle 3 -> ignored; result 12'h200 only, one DONE.
- Start A=200, assert RST asynchronously on cycle 4 -> READY=1, BCD=0, NEG=0 immediately, no DONE. A new START with A=42 after release -> 12'h042.
